// File: rtl/trace_replay_source_pkg.sv
// Shared types for the trace replay engine.
package trace_replay_source_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } replay_state_t;

endpackage

// File: rtl/trace_replay_source_sync_fifo.sv
// Show-ahead synchronous FIFO with flush; read data valid whenever !empty.
// Push and pop in the same cycle are accepted even when full; push while full without pop is dropped.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !flush && (!full || pop);
  assign rd_en = pop && !flush && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trace_replay_source.sv
// Replays a block of SRAM words onto an AXI-Stream master; first beat 3 cycles after start.
// Reads are throttled so in-flight plus buffered words never exceed FIFO_DEPTH under backpressure.
module trace_replay_source
  import trace_replay_source_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH:0] ONE = 1;

  replay_state_t         state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  inflight, inflight_last;
  logic                  issue, flush, beat, start_ok, can_issue;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count, occupancy;
  logic [DATA_WIDTH:0]   fifo_dout;

  assign occupancy = fifo_count + CW'(inflight);
  assign can_issue = !fifo_full && (occupancy < CW'(FIFO_DEPTH));
  assign start_ok  = (state == IDLE) && start && !abort;
  assign beat      = m_tvalid && m_tready;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = (num_words == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        issue = can_issue;
        if (abort) begin
          state_nxt = DONE;
          flush     = 1'b1;
        end else if (issue && remaining == ONE) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nxt = DONE;
          flush     = 1'b1;
        end else if (beat && m_tlast) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_nxt;
      // a read issued during an abort cycle returns after the flush and is dropped
      inflight      <= issue && !flush;
      inflight_last <= issue && (remaining == ONE);
      if (start_ok) begin
        addr      <= base_addr;
        remaining <= num_words;
      end else if (issue) begin
        addr      <= addr + ADDR_WIDTH'(1);
        remaining <= remaining - ONE;
      end
    end
  end

  sync_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (inflight),
    .din   ({inflight_last, mem_read_data}),
    .pop   (beat),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign mem_read_en = issue;
  assign mem_addr    = addr;
  assign m_tvalid    = !fifo_empty;
  assign m_tdata     = fifo_empty ? '0 : fifo_dout[DATA_WIDTH-1:0];
  assign m_tlast     = !fifo_empty && fifo_dout[DATA_WIDTH];

endmodule
